// File: rtl/overlay_c3x2_result_collector_if.sv
// ---------------------------------------------------------------------------
// overlay_c3x2_result_collector_if
// Bundles the issue handshake, the MAC result taps and the output stream of
// the C3x2 result collector.
//   issue_valid / issue_mode / issue_ready : operand-issue credit handshake
//   mac_s / mac_carry                      : registered MAC sum and carries
//   out_valid / out_ready / out_mode / out_data : result stream
//   inflight                               : accepted issues not yet captured
// The collector uses the slave modport; the operand source / consumer side
// uses the master modport.
// ---------------------------------------------------------------------------
interface overlay_c3x2_result_collector_if;
    logic        issue_valid;
    logic        issue_mode;
    logic        issue_ready;
    logic [44:0] mac_s;
    logic [3:0]  mac_carry;
    logic        out_valid;
    logic        out_ready;
    logic        out_mode;
    logic [48:0] out_data;
    logic [3:0]  inflight;

    modport slave (
        input  issue_valid, issue_mode, mac_s, mac_carry, out_ready,
        output issue_ready, out_valid, out_mode, out_data, inflight
    );

    modport master (
        output issue_valid, issue_mode, mac_s, mac_carry, out_ready,
        input  issue_ready, out_valid, out_mode, out_data, inflight
    );
endinterface

// File: rtl/overlay_c3x2_result_collector.sv
// ---------------------------------------------------------------------------
// overlay_c3x2_result_collector
// Receiving end of the C3x2 27x18 overlay MAC result path. Tracks accepted
// issues through a LATENCY-deep strobe pipeline, captures mac_s/mac_carry on
// the edge LATENCY cycles after each accept, unpacks them per mode and queues
// them in a fall-through FIFO. Issues are only granted while a FIFO slot is
// guaranteed for their result (count + inflight < DEPTH).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : collector interface (slave modport), see the interface file
// Parameters:
//   LATENCY : accept-to-capture distance in edges, 1..8
//   DEPTH   : FIFO entries, power of two, 2..16
// ---------------------------------------------------------------------------
module overlay_c3x2_result_collector #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    overlay_c3x2_result_collector_if.slave       bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Result layout per mode. In SIMD mode each lane keeps only its own
    // carry-out (carry[3] for the upper lane, carry[1] for the lower lane).
    function automatic logic [48:0] unpack_result(
        input logic        mode,
        input logic [44:0] s,
        input logic [3:0]  c
    );
        logic [48:0] r;
        if (mode == 1'b0) begin
            r = {c, s};
        end else begin
            r = {1'b0, c[3], s[44:22], 1'b0, c[1], s[21:0]};
        end
        return r;
    endfunction

    logic [LATENCY-1:0] pipe_valid_r;
    logic [LATENCY-1:0] pipe_mode_r;
    logic [49:0]        mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      count_nxt_s;
    logic [3:0]         inflight_r;
    logic [3:0]         inflight_nxt_s;
    logic [5:0]         used_nxt_s;
    logic               out_valid_r;
    logic               credit_ok_r;
    logic               accept_s;
    logic               capture_s;
    logic               capture_mode_s;
    logic               pop_s;

    assign accept_s       = bus.issue_valid & bus.issue_ready;
    assign capture_s      = pipe_valid_r[LATENCY-1];
    assign capture_mode_s = pipe_mode_r[LATENCY-1];
    assign pop_s          = out_valid_r & bus.out_ready;

    // Strobe pipeline: one stage per cycle of MAC latency; the tail stage
    // marks the edge on which the MAC output belongs to an accepted issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_valid_r <= '0;
            pipe_mode_r  <= '0;
        end else begin
            pipe_valid_r[0] <= accept_s;
            pipe_mode_r[0]  <= accept_s & bus.issue_mode;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_mode_r[i]  <= pipe_mode_r[i-1];
            end
        end
    end

    // Result FIFO storage and pointers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 50'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (capture_s) begin
                mem_r[wr_ptr_r] <= {capture_mode_s,
                                    unpack_result(capture_mode_s, bus.mac_s, bus.mac_carry)};
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Next occupancy and in-flight counts; simultaneous inc/dec cancel.
    always_comb begin
        count_nxt_s    = count_r;
        inflight_nxt_s = inflight_r;
        if (capture_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!capture_s && pop_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (accept_s && !capture_s) begin
            inflight_nxt_s = inflight_r + 4'd1;
        end else if (!accept_s && capture_s) begin
            inflight_nxt_s = inflight_r - 4'd1;
        end else begin
            inflight_nxt_s = inflight_r;
        end
        used_nxt_s = 6'(count_nxt_s) + 6'(inflight_nxt_s);
    end

    // Counters plus the registered flags derived from their next values, so
    // out_valid and the credit flag come straight from flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r     <= '0;
            inflight_r  <= 4'd0;
            out_valid_r <= 1'b0;
            credit_ok_r <= 1'b1;
        end else begin
            count_r     <= count_nxt_s;
            inflight_r  <= inflight_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            credit_ok_r <= (used_nxt_s < 6'(DEPTH));
        end
    end

    // Credit flag is gated by reset so no issue is granted while in reset.
    assign bus.issue_ready = credit_ok_r & reset;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_mode    = mem_r[rd_ptr_r][49];
    assign bus.out_data    = mem_r[rd_ptr_r][48:0];
    assign bus.inflight    = inflight_r;

endmodule

// File: tb/tb_overlay_c3x2_result_collector.sv
module tb_overlay_c3x2_result_collector;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   edge_n;
    logic mac_auto;
    logic [49:0] exp_q [$];

    overlay_c3x2_result_collector_if bus ();

    overlay_c3x2_result_collector #(.LATENCY(3), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value the bench drives on mac_s during the cycle after edge n.
    function automatic logic [44:0] mac_tag(input int n);
        return {13'h1A5, 32'(n)};
    endfunction

    // Expected mode-0 result for an issue accepted at edge e: the capture
    // edge is e+3, which samples the values driven after edge e+2.
    function automatic logic [49:0] exp_m0(input int e);
        int n;
        n = e + 2;
        return {1'b0, 4'(n), mac_tag(n)};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (mac_auto) begin
            bus.mac_s     = mac_tag(edge_n);
            bus.mac_carry = 4'(edge_n);
        end
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && b > 0) begin
            if (bus.out_valid) begin
                check_val("drain_data", 64'({bus.out_mode, bus.out_data}), 64'(exp_q.pop_front()));
            end
            tick();
            b--;
        end
        bus.out_ready = 1'b0;
        check_val("drain_done", 64'(exp_q.size()), 64'd0);
        check_val("drain_empty", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic single_issue(input logic mode, input logic [44:0] s, input logic [3:0] c,
                                input logic [49:0] exp);
        mac_auto        = 1'b0;
        bus.mac_s       = 45'h0F0F0F0F0F0;
        bus.mac_carry   = 4'h5;
        bus.issue_valid = 1'b1;
        bus.issue_mode  = mode;
        check_val("one_rdy", 64'(bus.issue_ready), 64'd1);
        tick();
        bus.issue_valid = 1'b0;
        bus.mac_s       = 45'h1DEADBEEF00;
        check_val("one_infl", 64'(bus.inflight), 64'd1);
        tick();
        check_val("one_early1", 64'(bus.out_valid), 64'd0);
        tick();
        check_val("one_early2", 64'(bus.out_valid), 64'd0);
        bus.mac_s     = s;
        bus.mac_carry = c;
        tick();
        bus.mac_s     = 45'h0F0F0F0F0F0;
        bus.mac_carry = 4'h5;
        check_val("one_valid", 64'(bus.out_valid), 64'd1);
        check_val("one_data", 64'({bus.out_mode, bus.out_data}), 64'(exp));
        check_val("one_infl0", 64'(bus.inflight), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val("one_popped", 64'(bus.out_valid), 64'd0);
        mac_auto = 1'b1;
    endtask

    initial begin
        logic [4:0] pat;
        n_checks        = 0;
        n_fail          = 0;
        edge_n          = 0;
        mac_auto        = 1'b1;
        reset           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_mode  = 1'b0;
        bus.out_ready   = 1'b0;
        bus.mac_s       = 45'd0;
        bus.mac_carry   = 4'd0;

        // reset state
        tick();
        tick();
        check_val("rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_infl", 64'(bus.inflight), 64'd0);
        check_val("rst_rdy", 64'(bus.issue_ready), 64'd0);
        check_val("rst_data", 64'({bus.out_mode, bus.out_data}), 64'd0);
        reset = 1'b1;
        #1;
        check_val("rel_rdy", 64'(bus.issue_ready), 64'd1);
        check_val("rel_valid", 64'(bus.out_valid), 64'd0);

        // single mode-0 and SIMD issues
        single_issue(1'b0, 45'h123456789AB, 4'hA, {1'b0, 4'hA, 45'h123456789AB});
        single_issue(1'b1, {23'h7FFFFF, 22'h000001}, 4'b1010,
                     {1'b1, 1'b0, 24'hFFFFFF, 1'b0, 23'h400001});

        // credit stall
        bus.issue_valid = 1'b1;
        bus.issue_mode  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("stall_rdy_open", 64'(bus.issue_ready), 64'd1);
            tick();
            exp_q.push_back(exp_m0(edge_n));
        end
        for (int i = 0; i < 4; i++) begin
            check_val("stall_rdy_shut", 64'(bus.issue_ready), 64'd0);
            tick();
        end
        check_val("stall_valid", 64'(bus.out_valid), 64'd1);
        check_val("stall_infl", 64'(bus.inflight), 64'd0);
        check_val("stall_head", 64'({bus.out_mode, bus.out_data}), 64'(exp_q[0]));
        bus.out_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        bus.out_ready = 1'b0;
        check_val("stall_rdy_back", 64'(bus.issue_ready), 64'd1);
        tick();
        exp_q.push_back(exp_m0(edge_n));
        bus.issue_valid = 1'b0;
        check_val("stall_rdy_again", 64'(bus.issue_ready), 64'd0);
        drain(20);

        // simultaneous capture and pop with count = 3, inflight = 1
        bus.issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("simul_rdy_open", 64'(bus.issue_ready), 64'd1);
            tick();
            exp_q.push_back(exp_m0(edge_n));
        end
        bus.issue_valid = 1'b0;
        tick();
        tick();
        check_val("simul_infl1", 64'(bus.inflight), 64'd1);
        check_val("simul_head", 64'({bus.out_mode, bus.out_data}), 64'(exp_q.pop_front()));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val("simul_infl0", 64'(bus.inflight), 64'd0);
        check_val("simul_valid", 64'(bus.out_valid), 64'd1);
        check_val("simul_rdy", 64'(bus.issue_ready), 64'd1);
        drain(20);

        // bubbles: issue pattern 1,0,1,1,0
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            bus.issue_valid = pat[i];
            check_val("bub_rdy", 64'(bus.issue_ready), 64'd1);
            tick();
            if (pat[i]) begin
                exp_q.push_back(exp_m0(edge_n));
            end
        end
        bus.issue_valid = 1'b0;
        drain(20);
        tick();
        tick();
        check_val("bub_idle", 64'(bus.out_valid), 64'd0);

        // reset mid-flight
        bus.issue_valid = 1'b1;
        tick();
        tick();
        bus.issue_valid = 1'b0;
        check_val("mid_infl", 64'(bus.inflight), 64'd2);
        reset = 1'b0;
        #1;
        check_val("mid_rdy_low", 64'(bus.issue_ready), 64'd0);
        tick();
        check_val("mid_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid_infl0", 64'(bus.inflight), 64'd0);
        reset = 1'b1;
        #1;
        check_val("mid_rdy_rel", 64'(bus.issue_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("mid_no_cap", 64'(bus.out_valid), 64'd0);
        end
        check_val("mid_infl_end", 64'(bus.inflight), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
